// File: rtl/fetch_ras_pkg.sv
// rtl/fetch_ras_pkg.sv - shared constants, types and slot arbitration for the fetch return address stack
package fetch_ras_pkg;

  localparam int RAS_DEPTH = 16;
  localparam int ADDR_W    = 64;
  localparam int PC_INC    = 4;

  typedef enum logic [1:0] {
    RAS_NONE = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2
  } ras_op_e;

  // Acting operation of a bundle and the slot it came from (0 = slot 1, 1 = slot 2)
  typedef struct packed {
    ras_op_e op;
    logic    slot;
  } ras_act_t;

  // The first control transfer in the bundle acts; anything after it is squashed
  function automatic ras_act_t ras_arbitrate(
    input logic bsr_1,
    input logic ret_1,
    input logic uncond_1,
    input logic bsr_2,
    input logic ret_2
  );
    ras_act_t act;
    act.op   = RAS_NONE;
    act.slot = 1'b0;
    if (bsr_1) begin
      act.op = RAS_PUSH;
    end else if (ret_1) begin
      act.op = RAS_POP;
    end else if (uncond_1) begin
      act.op = RAS_NONE;
    end else if (bsr_2) begin
      act.op   = RAS_PUSH;
      act.slot = 1'b1;
    end else if (ret_2) begin
      act.op   = RAS_POP;
      act.slot = 1'b1;
    end
    return act;
  endfunction

endpackage

// File: rtl/fetch_ras_if.sv
// rtl/fetch_ras_if.sv - fetch-side bundle, recovery and prediction signals of the return address stack
interface fetch_ras_if
  import fetch_ras_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = fetch_ras_pkg::ADDR_W
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              bsr_1;
  logic              bsr_2;
  logic              ret_1;
  logic              ret_2;
  logic              uncond_1;
  logic              recover;
  logic [PTR_W-1:0]  recover_tos;
  logic [PTR_W:0]    recover_count;
  logic              ret_pred_valid;
  logic [ADDR_W-1:0] ret_pred_target;
  logic              ret_pred_slot;
  logic [PTR_W-1:0]  ckpt_tos;
  logic [PTR_W:0]    ckpt_count;

  modport master (
    output fetch_valid, fetch_pc, bsr_1, bsr_2, ret_1, ret_2, uncond_1,
           recover, recover_tos, recover_count,
    input  ret_pred_valid, ret_pred_target, ret_pred_slot, ckpt_tos, ckpt_count
  );

  modport slave (
    input  fetch_valid, fetch_pc, bsr_1, bsr_2, ret_1, ret_2, uncond_1,
           recover, recover_tos, recover_count,
    output ret_pred_valid, ret_pred_target, ret_pred_slot, ckpt_tos, ckpt_count
  );

endinterface

// File: rtl/fetch_ras_regfile.sv
// rtl/fetch_ras_regfile.sv - DEPTH x ADDR_W stack storage, one sync write, one async read, async clear
module ras_regfile #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 64,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Entry write on push; whole array cleared while reset is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ras.sv
// rtl/fetch_ras.sv - two-wide return address stack with checkpoint restore for the fetch stage
module fetch_ras #(
  parameter int DEPTH  = fetch_ras_pkg::RAS_DEPTH,
  parameter int ADDR_W = fetch_ras_pkg::ADDR_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input logic        clock,
  input logic        reset,
  fetch_ras_if.slave bus
);
  import fetch_ras_pkg::*;

  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_1      = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] INC_2      = ADDR_W'(2 * PC_INC);

  logic [PTR_W-1:0]  tos;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  tos_inc;
  logic [PTR_W-1:0]  tos_dec;
  ras_act_t          act;
  logic              fetch_go;
  logic              do_push;
  logic              do_pop;
  logic              stack_nonempty;
  logic [ADDR_W-1:0] push_pc;
  logic [ADDR_W-1:0] top_entry;

  // Pick the acting slot and decide whether this bundle moves the stack
  always_comb begin
    act            = ras_arbitrate(bus.bsr_1, bus.ret_1, bus.uncond_1, bus.bsr_2, bus.ret_2);
    stack_nonempty = (count != '0);
    // Recovery overrides the bundle in the same cycle
    fetch_go       = bus.fetch_valid && !bus.recover;
    do_push        = fetch_go && (act.op == RAS_PUSH);
    do_pop         = fetch_go && (act.op == RAS_POP) && stack_nonempty;
    push_pc        = bus.fetch_pc + (act.slot ? INC_2 : INC_1);
    // Power-of-two depth lets the pointer wrap by plain overflow
    tos_inc        = tos + 1'b1;
    tos_dec        = tos - 1'b1;
  end

  // Pointer and occupancy: restore on recover, else follow the acting push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tos   <= '0;
      count <= '0;
    end else if (bus.recover) begin
      tos   <= bus.recover_tos;
      count <= bus.recover_count;
    end else if (do_push) begin
      tos <= tos_inc;
      // On overflow the oldest entry is overwritten and occupancy saturates
      if (count != COUNT_FULL) begin
        count <= count + 1'b1;
      end
    end else if (do_pop) begin
      tos   <= tos_dec;
      count <= count - 1'b1;
    end
  end

  ras_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (do_push),
    .waddr (tos_inc),
    .wdata (push_pc),
    .raddr (tos),
    .rdata (top_entry)
  );

  // Same-cycle prediction from the current top of stack
  always_comb begin
    bus.ret_pred_valid  = do_pop;
    bus.ret_pred_target = top_entry;
    bus.ret_pred_slot   = (act.op == RAS_POP) ? act.slot : 1'b0;
    bus.ckpt_tos        = tos;
    bus.ckpt_count      = count;
  end

endmodule

// File: tb/tb_fetch_ras.sv
// tb/tb_fetch_ras.sv - directed self-checking bench for fetch_ras
module tb_fetch_ras;
  import fetch_ras_pkg::*;

  localparam int DEPTH  = 16;
  localparam int AW     = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [3:0] ck_tos;
  logic [4:0] ck_count;

  fetch_ras_if #(.DEPTH(DEPTH), .ADDR_W(AW)) bus ();

  fetch_ras #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic b1, input logic r1,
                       input logic u1, input logic b2, input logic r2);
    bus.fetch_valid = v;
    bus.fetch_pc    = pc;
    bus.bsr_1       = b1;
    bus.ret_1       = r1;
    bus.uncond_1    = u1;
    bus.bsr_2       = b2;
    bus.ret_2       = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic state(input string tag, input logic [63:0] tos_exp, input logic [63:0] cnt_exp);
    chk({tag, "_tos"}, 64'(bus.ckpt_tos), tos_exp);
    chk({tag, "_count"}, 64'(bus.ckpt_count), cnt_exp);
  endtask

  initial begin
    bus.recover       = 1'b0;
    bus.recover_tos   = '0;
    bus.recover_count = '0;
    drive(1'b0, 64'h0, 0, 0, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_valid", 64'(bus.ret_pred_valid), 64'd0);
    chk("rst_target", bus.ret_pred_target, 64'd0);
    chk("rst_slot", 64'(bus.ret_pred_slot), 64'd0);
    state("rst", 64'd0, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // RET on empty stack
    drive(1'b1, 64'h100, 0, 1, 0, 0, 0);
    chk("empty_ret_valid", 64'(bus.ret_pred_valid), 64'd0);
    tick();
    state("empty_ret", 64'd0, 64'd0);

    // Slot-1 BSR then RET
    drive(1'b1, 64'h1000, 1, 0, 0, 0, 0);
    tick();
    state("bsr1", 64'd1, 64'd1);
    drive(1'b1, 64'h1010, 0, 1, 0, 0, 0);
    chk("ret1_valid", 64'(bus.ret_pred_valid), 64'd1);
    chk("ret1_target", bus.ret_pred_target, 64'h1004);
    chk("ret1_slot", 64'(bus.ret_pred_slot), 64'd0);
    tick();
    state("ret1", 64'd0, 64'd0);

    // Slot-2 BSR then slot-2 RET
    drive(1'b1, 64'h2000, 0, 0, 0, 1, 0);
    tick();
    state("bsr2", 64'd1, 64'd1);
    drive(1'b1, 64'h2100, 0, 0, 0, 0, 1);
    chk("ret2_valid", 64'(bus.ret_pred_valid), 64'd1);
    chk("ret2_target", bus.ret_pred_target, 64'h2008);
    chk("ret2_slot", 64'(bus.ret_pred_slot), 64'd1);
    tick();
    state("ret2", 64'd0, 64'd0);

    // Both slots BSR: only slot 1 pushes
    drive(1'b1, 64'h3000, 1, 0, 0, 1, 0);
    tick();
    state("dbl_bsr", 64'd1, 64'd1);
    drive(1'b1, 64'h3100, 0, 1, 0, 0, 0);
    chk("dbl_bsr_target", bus.ret_pred_target, 64'h3004);
    tick();
    state("dbl_pop", 64'd0, 64'd0);

    // Unconditional slot 1 squashes slot-2 BSR; stalled bundle does nothing
    drive(1'b1, 64'h4000, 0, 0, 1, 1, 0);
    tick();
    state("uncond_squash", 64'd0, 64'd0);
    drive(1'b0, 64'h4000, 1, 0, 0, 0, 0);
    tick();
    state("stalled", 64'd0, 64'd0);

    // 17 pushes of 0x10..0x110: wrap through 15 -> 0, count saturates at 16
    for (int k = 1; k <= 17; k++) begin
      state($sformatf("push%0d", k), 64'((k - 1) % 16), 64'((k - 1 > 16) ? 16 : k - 1));
      drive(1'b1, 64'(16 * k - 4), 1, 0, 0, 0, 0);
      tick();
    end
    state("full", 64'd1, 64'd16);

    // 16 pops: 0x110 down to 0x20, tos wraps 0 -> 15
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 64'h8000, 0, 1, 0, 0, 0);
      state($sformatf("pop%0d", j), 64'((17 - j) % 16), 64'(16 - j));
      chk($sformatf("pop%0d_valid", j), 64'(bus.ret_pred_valid), 64'd1);
      chk($sformatf("pop%0d_target", j), bus.ret_pred_target, 64'(16'h110 - 16 * j));
      tick();
    end
    drive(1'b1, 64'h8000, 0, 1, 0, 0, 0);
    chk("pop16_valid", 64'(bus.ret_pred_valid), 64'd0);
    tick();
    state("drained", 64'd1, 64'd0);

    // Push A, B, capture checkpoint during C's bundle, then recover
    drive(1'b1, 64'h9FFC, 1, 0, 0, 0, 0);
    tick();
    drive(1'b1, 64'hAFFC, 1, 0, 0, 0, 0);
    tick();
    drive(1'b1, 64'hBFFC, 1, 0, 0, 0, 0);
    ck_tos   = bus.ckpt_tos;
    ck_count = bus.ckpt_count;
    tick();
    state("abc", 64'd4, 64'd3);
    bus.recover       = 1'b1;
    bus.recover_tos   = ck_tos;
    bus.recover_count = ck_count;
    drive(1'b1, 64'hD000, 0, 1, 0, 0, 0);
    chk("recover_valid", 64'(bus.ret_pred_valid), 64'd0);
    tick();
    bus.recover = 1'b0;
    state("recovered", 64'd3, 64'd2);
    drive(1'b1, 64'hD000, 0, 1, 0, 0, 0);
    chk("rec_ret_valid", 64'(bus.ret_pred_valid), 64'd1);
    chk("rec_ret_target", bus.ret_pred_target, 64'hB000);
    tick();
    drive(1'b1, 64'hD010, 0, 1, 0, 0, 0);
    chk("rec_ret2_target", bus.ret_pred_target, 64'hA000);
    tick();
    state("rec_popped", 64'd1, 64'd0);

    // Asynchronous reset between edges clears outputs immediately
    drive(1'b1, 64'hE000, 1, 0, 0, 0, 0);
    tick();
    drive(1'b0, 64'h0, 0, 0, 0, 0, 0);
    chk("pre_rst_target", bus.ret_pred_target, 64'hE004);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_target", bus.ret_pred_target, 64'd0);
    chk("arst_valid", 64'(bus.ret_pred_valid), 64'd0);
    state("arst", 64'd0, 64'd0);
    tick();
    reset = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
